// File: rtl/score_link.sv
// score_link: serial exchange of the 4-bit snake score on one wire; optional even parity bit under SCORE_LINK_PARITY_EN.
// Latency: TX frame starts 1 cycle after score changes; RX result ~BIT_CYCLES/2 + (N-1)*BIT_CYCLES after the start edge.
// Backpressure: none; TX sends only the newest score once idle, RX drops bad frames with a frame_err pulse.
module score_link #(
    parameter int BIT_CYCLES = 6771
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] score,
    input  logic       rx_line,
    output logic       tx_line,
    output logic       tx_busy,
    output logic [3:0] r_score,
    output logic       r_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------- transmitter ----------------
    state_t        tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [1:0]    tx_bit, tx_bit_n;
    logic [3:0]    tx_sh, tx_sh_n;
    logic [3:0]    last_sent, last_sent_n;
    logic          tx_line_n, tx_busy_n;
    logic          tx_end;

    assign tx_end = (tx_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state  <= S_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= '0;
            last_sent <= '0;
            tx_line   <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            tx_state  <= tx_state_n;
            tx_cnt    <= tx_cnt_n;
            tx_bit    <= tx_bit_n;
            tx_sh     <= tx_sh_n;
            last_sent <= last_sent_n;
            tx_line   <= tx_line_n;
            tx_busy   <= tx_busy_n;
        end
    end

    always_comb begin
        tx_state_n  = tx_state;
        tx_cnt_n    = '0;
        tx_bit_n    = tx_bit;
        tx_sh_n     = tx_sh;
        last_sent_n = last_sent;
        tx_line_n   = tx_line;
        tx_busy_n   = tx_busy;
        if (tx_state != S_IDLE && !tx_end) begin
            tx_cnt_n = tx_cnt + 1'b1;
        end
        case (tx_state)
            S_IDLE: begin
                // Compared on every idle cycle, so only the newest score is sent.
                if (score != last_sent) begin
                    tx_sh_n     = score;
                    last_sent_n = score;
                    tx_bit_n    = '0;
                    tx_line_n   = 1'b0;
                    tx_busy_n   = 1'b1;
                    tx_state_n  = S_START;
                end
            end
            S_START: begin
                if (tx_end) begin
                    tx_line_n  = tx_sh[0];
                    tx_state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_end) begin
                    if (tx_bit == 2'd3) begin
`ifdef SCORE_LINK_PARITY_EN
                        tx_line_n  = ^last_sent;
                        tx_state_n = S_PARITY;
`else
                        tx_line_n  = 1'b1;
                        tx_state_n = S_STOP;
`endif
                    end else begin
                        tx_bit_n  = tx_bit + 1'b1;
                        tx_sh_n   = {1'b0, tx_sh[3:1]};
                        tx_line_n = tx_sh[1];
                    end
                end
            end
`ifdef SCORE_LINK_PARITY_EN
            S_PARITY: begin
                if (tx_end) begin
                    tx_line_n  = 1'b1;
                    tx_state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tx_end) begin
                    tx_line_n  = 1'b1;
                    tx_busy_n  = 1'b0;
                    tx_state_n = S_IDLE;
                end
            end
            default: begin
                tx_line_n  = 1'b1;
                tx_busy_n  = 1'b0;
                tx_state_n = S_IDLE;
            end
        endcase
    end

    // ---------------- receiver ----------------
    state_t        rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [1:0]    rx_bit, rx_bit_n;
    logic [3:0]    rx_sh, rx_sh_n;
    logic [3:0]    r_score_n;
    logic          r_valid_n, frame_err_n;
    logic          rx_s1, rx_s2;
    logic          rx_fall, rx_end, par_ok;
`ifdef SCORE_LINK_PARITY_EN
    logic          rx_par, rx_par_n;
`endif

    // Edge taken as the new sample enters the second sync stage, saving a cycle;
    // a metastable false start is rejected by the mid-start-bit check.
    assign rx_fall = rx_s2 & ~rx_s1;
    assign rx_end  = (rx_cnt == CNT_LAST);
`ifdef SCORE_LINK_PARITY_EN
    assign par_ok  = (rx_par == ^rx_sh);
`else
    assign par_ok  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_state  <= S_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_sh     <= '0;
            r_score   <= '0;
            r_valid   <= 1'b0;
            frame_err <= 1'b0;
`ifdef SCORE_LINK_PARITY_EN
            rx_par    <= 1'b0;
`endif
        end else begin
            rx_s1     <= rx_line;
            rx_s2     <= rx_s1;
            rx_state  <= rx_state_n;
            rx_cnt    <= rx_cnt_n;
            rx_bit    <= rx_bit_n;
            rx_sh     <= rx_sh_n;
            r_score   <= r_score_n;
            r_valid   <= r_valid_n;
            frame_err <= frame_err_n;
`ifdef SCORE_LINK_PARITY_EN
            rx_par    <= rx_par_n;
`endif
        end
    end

    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt + 1'b1;
        rx_bit_n    = rx_bit;
        rx_sh_n     = rx_sh;
        r_score_n   = r_score;
        r_valid_n   = 1'b0;
        frame_err_n = 1'b0;
`ifdef SCORE_LINK_PARITY_EN
        rx_par_n    = rx_par;
`endif
        case (rx_state)
            S_IDLE: begin
                rx_cnt_n = '0;
                if (rx_fall) begin
                    rx_state_n = S_START;
                end
            end
            S_START: begin
                if (rx_cnt == CNT_HALF) begin
                    rx_cnt_n = '0;
                    rx_bit_n = '0;
                    rx_state_n = rx_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_end) begin
                    rx_cnt_n = '0;
                    rx_sh_n  = {rx_s2, rx_sh[3:1]};
                    if (rx_bit == 2'd3) begin
`ifdef SCORE_LINK_PARITY_EN
                        rx_state_n = S_PARITY;
`else
                        rx_state_n = S_STOP;
`endif
                    end else begin
                        rx_bit_n = rx_bit + 1'b1;
                    end
                end
            end
`ifdef SCORE_LINK_PARITY_EN
            S_PARITY: begin
                if (rx_end) begin
                    rx_cnt_n   = '0;
                    rx_par_n   = rx_s2;
                    rx_state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (rx_end) begin
                    rx_cnt_n   = '0;
                    rx_state_n = S_IDLE;
                    if (rx_s2 && par_ok) begin
                        r_score_n = rx_sh;
                        r_valid_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
            end
            default: begin
                rx_cnt_n   = '0;
                rx_state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_score_link.sv
// Directed bench for score_link at BIT_CYCLES=16: loopback, coalescing, injected bad frames, glitch and reset.
module tb_score_link;

    localparam int B = 16;
    localparam int H = B / 2;
`ifdef SCORE_LINK_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int N = PAR ? 7 : 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] score = 4'd0;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b1;
    logic       rx_line;
    logic       tx_line, tx_busy, r_valid, frame_err;
    logic [3:0] r_score;

    assign rx_line = loop_en ? tx_line : rx_drv;

    score_link #(.BIT_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .score(score), .rx_line(rx_line),
        .tx_line(tx_line), .tx_busy(tx_busy), .r_score(r_score),
        .r_valid(r_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int vld_cnt = 0, err_cnt = 0, both_cnt = 0, start_cnt = 0, vld_cyc = 0;
    logic busy_q = 1'b0;
    logic [3:0] rv_log[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (r_valid) begin
            vld_cnt++;
            vld_cyc = cyc;
            rv_log.push_back(r_score);
        end
        if (frame_err) err_cnt++;
        if (r_valid && frame_err) both_cnt++;
        if (tx_busy && !busy_q) start_cnt++;
        busy_q = tx_busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [3:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 4) return d[idx-1];
        if (PAR && idx == 5) return ^d;
        return 1'b1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic flip_par, input logic zero_stop);
        logic b;
        for (int i = 0; i < N; i++) begin
            b = frame_bit(d, i);
            if (PAR && flip_par && i == 5) b = ~b;
            if (zero_stop && i == N - 1) b = 1'b0;
            rx_drv = b;
            tick(B);
        end
        rx_drv = 1'b1;
        tick(6);
    endtask

    initial begin
        logic [6:0] exp_bits;
        int v0, e0, s0, q0, t_start, lat, exp_lat;

        // Reset state
        tick(3);
        check("rst_tx_line", 32'(tx_line), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_r_score", 32'(r_score), 32'd0);
        check("rst_r_valid", 32'(r_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        tick(10);
        check("idle_tx_line", 32'(tx_line), 32'd1);
        check("idle_no_start", 32'(start_cnt), 32'd0);

        // Loopback, score 0 -> 5
        exp_bits = PAR ? 7'b1001010 : 7'b0101010;
        v0 = vld_cnt; e0 = err_cnt;
        score = 4'd5;
        tick(1);
        t_start = cyc;
        check("f5_busy", 32'(tx_busy), 32'd1);
        for (int i = 0; i < N; i++) begin
            tick(H);
            check($sformatf("f5_bit%0d", i), 32'(tx_line), 32'(exp_bits[i]));
            tick(B - H);
        end
        check("f5_busy_end", 32'(tx_busy), 32'd0);
        check("f5_line_end", 32'(tx_line), 32'd1);
        check("f5_r_score", 32'(r_score), 32'd5);
        check("f5_vld_cnt", 32'(vld_cnt - v0), 32'd1);
        check("f5_err_cnt", 32'(err_cnt - e0), 32'd0);
        lat = vld_cyc - t_start;
        exp_lat = 2 + H + (N - 1) * B;
        check("f5_rx_latency_in_window", 32'(lat >= exp_lat - 1 && lat <= exp_lat + 1), 32'd1);

        // 3 -> 9 -> 12 within one frame: only 3 and 12 go out
        s0 = start_cnt; v0 = vld_cnt; q0 = rv_log.size();
        score = 4'd3;
        tick(20);
        score = 4'd9;
        tick(20);
        score = 4'd12;
        tick(2 * N * B + 150);
        check("coal_frames", 32'(start_cnt - s0), 32'd2);
        check("coal_vld_cnt", 32'(vld_cnt - v0), 32'd2);
        if (rv_log.size() >= q0 + 2) begin
            check("coal_first", 32'(rv_log[q0]), 32'd3);
            check("coal_second", 32'(rv_log[q0+1]), 32'd12);
        end else begin
            check("coal_log_len", 32'(rv_log.size() - q0), 32'd2);
        end
        check("coal_r_score", 32'(r_score), 32'd12);

        // Injected frames from the opponent side
        loop_en = 1'b0;
        tick(4);
        v0 = vld_cnt; e0 = err_cnt;
        send_frame(4'd6, 1'b1, 1'b0);
        check("par_err_cnt", 32'(err_cnt - e0), PAR ? 32'd1 : 32'd0);
        check("par_vld_cnt", 32'(vld_cnt - v0), PAR ? 32'd0 : 32'd1);
        check("par_r_score", 32'(r_score), PAR ? 32'd12 : 32'd6);

        v0 = vld_cnt; e0 = err_cnt;
        send_frame(4'd10, 1'b0, 1'b1);
        check("stop_err_cnt", 32'(err_cnt - e0), 32'd1);
        check("stop_vld_cnt", 32'(vld_cnt - v0), 32'd0);
        check("stop_r_score_hold", 32'(r_score), PAR ? 32'd12 : 32'd6);
        send_frame(4'd7, 1'b0, 1'b0);
        check("after_stop_r_score", 32'(r_score), 32'd7);
        check("after_stop_vld_cnt", 32'(vld_cnt - v0), 32'd1);

        // 5-cycle low glitch
        v0 = vld_cnt; e0 = err_cnt;
        rx_drv = 1'b0;
        tick(5);
        rx_drv = 1'b1;
        tick(3 * B);
        check("glitch_vld_cnt", 32'(vld_cnt - v0), 32'd0);
        check("glitch_err_cnt", 32'(err_cnt - e0), 32'd0);
        send_frame(4'd9, 1'b0, 1'b0);
        check("glitch_recover_r_score", 32'(r_score), 32'd9);

        // Reset in the middle of a loopback frame
        loop_en = 1'b1;
        score = 4'd4;
        tick(30);
        check("mid_busy", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        tick(1);
        check("mrst_tx_line", 32'(tx_line), 32'd1);
        check("mrst_tx_busy", 32'(tx_busy), 32'd0);
        check("mrst_r_score", 32'(r_score), 32'd0);
        tick(1);
        reset = 1'b0;
        v0 = vld_cnt;
        tick(1);
        check("post_rst_tx_line", 32'(tx_line), 32'd0);
        check("post_rst_tx_busy", 32'(tx_busy), 32'd1);
        tick(N * B + 12);
        check("post_rst_r_score", 32'(r_score), 32'd4);
        check("post_rst_vld_cnt", 32'(vld_cnt - v0), 32'd1);
        check("never_both_pulses", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
